// File: rtl/pipe_stage.sv
// Flow-controlled pipeline register carrying PC, PC+4, instruction, control and payload.
// Optional skid entry enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage #(
  parameter int unsigned CTRL_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned STALL_CNT_WIDTH = 16,
  parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [31:0]                i_pc,
  input  logic [31:0]                i_pc_incr,
  input  logic [31:0]                i_instr,
  input  logic [CTRL_WIDTH-1:0]      i_ctrl,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_pc,
  output logic [31:0]                o_pc_incr,
  output logic [31:0]                o_instr,
  output logic [CTRL_WIDTH-1:0]      o_ctrl,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [31:0]           pc;
    logic [31:0]           pc_incr;
    logic [31:0]           instr;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t m_q, m_d;
  beat_t in_beat, bubble;
  logic  ready_c;
  logic  in_xfer_c;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Bubble and incoming beat images
  always_comb begin
    bubble          = '0;
    bubble.instr    = NOP_INSTR;
    in_beat         = '0;
    in_beat.valid   = 1'b1;
    in_beat.pc      = i_pc;
    in_beat.pc_incr = i_pc_incr;
    in_beat.instr   = i_instr;
    in_beat.ctrl    = i_ctrl;
    in_beat.data    = i_data;
  end

  assign in_xfer_c = i_valid && ready_c;

`ifdef PIPE_STAGE_SKID_EN
  beat_t s_q, s_d;

  // Ready depends only on the skid entry, so it is a registered signal
  assign ready_c = !s_q.valid;

  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (i_flush) begin
      m_d = bubble;
      s_d = bubble;
    end else if (!m_q.valid || i_ready) begin
      if (s_q.valid) begin
        m_d = s_q;
        s_d = bubble;
      end else begin
        m_d = in_xfer_c ? in_beat : bubble;
      end
    end else if (in_xfer_c) begin
      s_d = in_beat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) s_q <= beat_t'({1'b0, 64'd0, NOP_INSTR, CTRL_WIDTH'(0), DATA_WIDTH'(0)});
    else          s_q <= s_d;
  end
`else
  assign ready_c = !m_q.valid || i_ready;

  always_comb begin
    m_d = m_q;
    if (i_flush)      m_d = bubble;
    else if (ready_c) m_d = i_valid ? in_beat : bubble;
  end
`endif

  // Saturating count of cycles with a beat held against back-pressure
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_q.valid && !i_ready && (stall_cnt_q != {STALL_CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_q         <= beat_t'({1'b0, 64'd0, NOP_INSTR, CTRL_WIDTH'(0), DATA_WIDTH'(0)});
      stall_cnt_q <= '0;
    end else begin
      m_q         <= m_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_ready     = ready_c;
  assign o_valid     = m_q.valid;
  assign o_pc        = m_q.pc;
  assign o_pc_incr   = m_q.pc_incr;
  assign o_instr     = m_q.instr;
  assign o_ctrl      = m_q.ctrl;
  assign o_data      = m_q.data;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage; expectations adapt to PIPE_STAGE_SKID_EN.
module tb_pipe_stage;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid, o_ready;
  logic [31:0]   i_pc, i_pc_incr, i_instr;
  logic [CW-1:0] i_ctrl;
  logic [DW-1:0] i_data;
  logic          i_flush;
  logic          o_valid, i_ready;
  logic [31:0]   o_pc, o_pc_incr, o_instr;
  logic [CW-1:0] o_ctrl;
  logic [DW-1:0] o_data;
  logic [SW-1:0] o_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipe_stage #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW), .NOP_INSTR(NOP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_pc_incr(i_pc_incr), .i_instr(i_instr), .i_ctrl(i_ctrl), .i_data(i_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_pc_incr(o_pc_incr), .o_instr(o_instr), .o_ctrl(o_ctrl), .o_data(o_data),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Derived fields make every beat distinguishable by pc alone
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [31:0] pc);
    logic [63:0] d;
    d = {~pc, pc};
    return DW'(d);
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    i_valid   = v;
    i_pc      = pc;
    i_pc_incr = pc + 32'd4;
    i_instr   = instr_of(pc);
    i_ctrl    = CW'(pc ^ 32'h5A5A);
    i_data    = data_of(pc);
  endtask

  task automatic test_reset();
    i_ready = 1'b0;
    drive(1'b1, 32'h400);
    tick();
    drive(1'b1, 32'h404);
    tick();
    #2;
    i_rst_n = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", o_valid); end
    vectors++; if (o_instr !== NOP) begin miscompares++; $display("FAIL rst_instr got %h want %h", o_instr, NOP); end
    vectors++; if (o_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want 0", o_pc); end
    vectors++; if (o_stall_cnt !== SW'(0)) begin miscompares++; $display("FAIL rst_cnt got %0d want 0", o_stall_cnt); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", o_ready); end
    tick();
    i_rst_n = 1'b1;
    tick();
    vectors++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst got v=%b r=%b want v=0 r=1", o_valid, o_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pc = 32'h100 + 32'(4 * k);
      drive(1'b1, pc);
      tick();
      vectors++; if (o_valid !== 1'b1 || o_pc !== pc) begin miscompares++; $display("FAIL b2b_beat[%0d] got v=%b pc=%h want v=1 pc=%h", k, o_valid, o_pc, pc); end
      vectors++; if (o_instr !== instr_of(pc) || o_pc_incr !== pc + 32'd4 || o_data !== data_of(pc)) begin miscompares++; $display("FAIL b2b_fields[%0d] got instr=%h incr=%h want instr=%h incr=%h", k, o_instr, o_pc_incr, instr_of(pc), pc + 32'd4); end
      vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got %b want 1", k, o_ready); end
    end
    drive(1'b0, 32'h0);
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %b want 0", o_valid); end
  endtask

  task automatic test_stall();
    i_ready = 1'b1;
    drive(1'b1, 32'h200);
    tick();
    i_ready = 1'b0;
    drive(1'b1, 32'h204);
`ifdef PIPE_STAGE_SKID_EN
    #1;
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL stall_skid_ready got %b want 1", o_ready); end
`endif
    for (int c = 1; c <= 5; c++) begin
      tick();
`ifdef PIPE_STAGE_SKID_EN
      i_valid = 1'b0;
`endif
      vectors++; if (o_valid !== 1'b1 || o_pc !== 32'h200) begin miscompares++; $display("FAIL stall_hold[%0d] got v=%b pc=%h want v=1 pc=200", c, o_valid, o_pc); end
      vectors++; if (o_stall_cnt !== SW'(c)) begin miscompares++; $display("FAIL stall_cnt[%0d] got %0d want %0d", c, o_stall_cnt, c); end
      vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready[%0d] got %b want 0", c, o_ready); end
    end
    i_ready = 1'b1;
    tick();
    drive(1'b0, 32'h0);
    vectors++; if (o_valid !== 1'b1 || o_pc !== 32'h204) begin miscompares++; $display("FAIL stall_second got v=%b pc=%h want v=1 pc=204", o_valid, o_pc); end
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got %b want 0", o_valid); end
    vectors++; if (o_stall_cnt !== SW'(5)) begin miscompares++; $display("FAIL stall_cnt_keep got %0d want 5", o_stall_cnt); end
  endtask

  task automatic test_flush();
    i_ready = 1'b1;
    drive(1'b1, 32'h2F0);
    tick();
    i_ready = 1'b0;
    drive(1'b1, 32'h2F4);
    tick();
    i_ready = 1'b1;
    i_flush = 1'b1;
    drive(1'b1, 32'h300);
    tick();
    i_flush = 1'b0;
    drive(1'b0, 32'h0);
    vectors++; if (o_valid !== 1'b0 || o_instr !== NOP) begin miscompares++; $display("FAIL flush_bubble got v=%b instr=%h want v=0 instr=%h", o_valid, o_instr, NOP); end
    vectors++; if (o_pc !== 32'h0 || o_ctrl !== CW'(0)) begin miscompares++; $display("FAIL flush_fields got pc=%h ctrl=%h want 0", o_pc, o_ctrl); end
    vectors++; if (o_stall_cnt !== SW'(6)) begin miscompares++; $display("FAIL flush_cnt got %0d want 6", o_stall_cnt); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", o_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL flush_leak[%0d] got v=%b pc=%h want v=0", c, o_valid, o_pc); end
    end
  endtask

  task automatic test_saturate();
    int exp;
    i_ready = 1'b1;
    drive(1'b1, 32'h500);
    tick();
    i_ready = 1'b0;
    drive(1'b0, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp = (6 + c > 15) ? 15 : 6 + c;
      vectors++; if (o_stall_cnt !== SW'(exp)) begin miscompares++; $display("FAIL sat_cnt[%0d] got %0d want %0d", c, o_stall_cnt, exp); end
    end
    vectors++; if (o_pc !== 32'h500 || o_valid !== 1'b1) begin miscompares++; $display("FAIL sat_hold got v=%b pc=%h want v=1 pc=500", o_valid, o_pc); end
    i_ready = 1'b1;
    tick();
    vectors++; if (o_valid !== 1'b0 || o_stall_cnt !== SW'(15)) begin miscompares++; $display("FAIL sat_after got v=%b cnt=%0d want v=0 cnt=15", o_valid, o_stall_cnt); end
  endtask

  task automatic test_alternate();
    logic [31:0] pc;
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pc = 32'h600 + 32'(4 * k);
      drive((k % 2) == 0, pc);
      tick();
      if ((k % 2) == 0) begin
        vectors++; if (o_valid !== 1'b1 || o_pc !== pc || o_ctrl !== CW'(pc ^ 32'h5A5A)) begin miscompares++; $display("FAIL alt_beat[%0d] got v=%b pc=%h want v=1 pc=%h", k, o_valid, o_pc, pc); end
      end else begin
        vectors++; if (o_valid !== 1'b0 || o_instr !== NOP || o_ctrl !== CW'(0) || o_pc !== 32'h0 || o_data !== DW'(0)) begin miscompares++; $display("FAIL alt_bubble[%0d] got v=%b instr=%h ctrl=%h want v=0 instr=%h ctrl=0", k, o_valid, o_instr, o_ctrl, NOP); end
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturate();
    test_alternate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
